// File: rtl/aq_spsram_pkg.sv
// rtl/aq_spsram_pkg.sv - shared types and constants for the single-port SRAM controller
package aq_spsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } aq_spsram_state_e;

    localparam int RSP_FIFO_DEPTH = 4;
    localparam int RSP_PTR_W      = 2;
    localparam int CREDIT_W       = 3;

endpackage

// File: rtl/aq_spsram_if.sv
// rtl/aq_spsram_if.sv - request/response stream bundle between refill logic and the SRAM controller
interface aq_spsram_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/aq_spsram_rsp_fifo.sv
// rtl/aq_spsram_rsp_fifo.sv - 4-entry read-response FIFO; push and pop may coincide at any occupancy
module aq_spsram_rsp_fifo
    import aq_spsram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0]  wr_ptr;
    logic [RSP_PTR_W-1:0]  rd_ptr;
    logic [RSP_PTR_W:0]    count;

    assign full  = (count == (RSP_PTR_W + 1)'(RSP_FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + RSP_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + RSP_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (RSP_PTR_W + 1)'(1);
                2'b01:   count <= count - (RSP_PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Read credits bound occupancy, so a push into a full FIFO without a pop is a controller bug.
    a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
        !(push && full && !pop));

endmodule

// File: rtl/aq_spsram_ctrl.sv
// rtl/aq_spsram_ctrl.sv - single-port SRAM initiator with credit-limited in-order read returns; AQ_SPSRAM_INIT_EN adds a post-reset zero-fill sweep
module aq_spsram_ctrl
    import aq_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    aq_spsram_if.slave            bus,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  init_done
);

    logic [CREDIT_W-1:0] rd_credit;
    logic                rd_s1;
    logic                rd_s2;
    logic                run;
    logic                req_acc;
    logic                rd_acc;
    logic                rsp_pop;
    logic                fifo_full;
    logic                fifo_empty;

`ifdef AQ_SPSRAM_INIT_EN
    aq_spsram_state_e      state;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    assign run = (state == ST_RUN);
`else
    assign run = 1'b1;
`endif

    assign init_done   = run;
    // Writes never need a credit; reads stall once every FIFO slot is spoken for.
    assign bus.req_rdy = cpurst_b & run & (bus.req_wr | (rd_credit < CREDIT_W'(RSP_FIFO_DEPTH)));
    assign req_acc     = bus.req_vld & bus.req_rdy;
    assign rd_acc      = req_acc & ~bus.req_wr;
    assign bus.rsp_vld = ~fifo_empty;
    assign rsp_pop     = bus.rsp_vld & bus.rsp_rdy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sram_a    <= '0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_d    <= '0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            rd_credit <= '0;
`ifdef AQ_SPSRAM_INIT_EN
            state      <= ST_INIT;
            sweep_addr <= '0;
`endif
        end else begin
            rd_s1 <= rd_acc;
            rd_s2 <= rd_s1;
            case ({rd_acc, rsp_pop})
                2'b10:   rd_credit <= rd_credit + CREDIT_W'(1);
                2'b01:   rd_credit <= rd_credit - CREDIT_W'(1);
                default: rd_credit <= rd_credit;
            endcase
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
`ifdef AQ_SPSRAM_INIT_EN
            if (state == ST_INIT) begin
                sram_cen   <= 1'b0;
                sram_gwen  <= 1'b0;
                sram_wen   <= '0;
                sram_a     <= sweep_addr;
                sram_d     <= '0;
                sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
                if (&sweep_addr) begin
                    state <= ST_RUN;
                end
            end
`endif
            if (req_acc) begin
                sram_cen  <= 1'b0;
                sram_a    <= bus.req_addr;
                sram_gwen <= ~bus.req_wr;
                sram_wen  <= bus.req_wr ? ~bus.req_wmask : '1;
                sram_d    <= bus.req_wdata;
            end
        end
    end

    // rd_s2 is the cycle the macro presents Q for the read issued two edges earlier.
    aq_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .push           (rd_s2),
        .push_data      (sram_q),
        .pop            (rsp_pop),
        .head           (bus.rsp_rdata),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_aq_spsram_ctrl.sv
// tb/tb_aq_spsram_ctrl.sv - directed bench for aq_spsram_ctrl with a behavioural SRAM model
module tb_aq_spsram_ctrl;

    logic       forever_cpuclk = 1'b0;
    logic       cpurst_b;
    logic [6:0] sram_a;
    logic       sram_cen;
    logic       sram_gwen;
    logic [7:0] sram_wen;
    logic [7:0] sram_d;
    logic [7:0] sram_q;
    logic       init_done;
    logic [7:0] mem [128];

    int nvec = 0;
    int nerr = 0;

    aq_spsram_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    aq_spsram_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .bus            (bus),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q),
        .init_done      (init_done)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge forever_cpuclk);
        #2;
    endtask

    task automatic drive(input logic v, input logic w, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] m);
        bus.req_vld   = v;
        bus.req_wr    = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    task automatic wr_op(input logic [6:0] a, input logic [7:0] d, input logic [7:0] m);
        drive(1'b1, 1'b1, a, d, m);
        #1 chk("wr_rdy", bus.req_rdy, 1);
        step();
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
    endtask

    task automatic rd_op(input logic [6:0] a);
        drive(1'b1, 1'b0, a, 8'd0, 8'd0);
        #1 chk("rd_rdy", bus.req_rdy, 1);
        step();
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [7:0] exp);
        rd_op(a);
        chk("rd_lat_n1", bus.rsp_vld, 0);
        step();
        chk("rd_lat_n2", bus.rsp_vld, 0);
        step();
        chk("rd_lat_n3", bus.rsp_vld, 1);
        chk("rd_data", bus.rsp_rdata, exp);
        step();
    endtask

`ifdef AQ_SPSRAM_INIT_EN
    task automatic check_sweep(input int nwr);
        for (int i = 0; i < nwr; i++) begin
            step();
            chk("sweep_a", sram_a, i);
            chk("sweep_strobes", {sram_cen, sram_gwen, sram_wen, sram_d}, 0);
            chk("sweep_not_done", {init_done, bus.req_rdy}, 0);
        end
        if (nwr == 128) begin
            step();
            chk("sweep_done", init_done, 1);
        end
    endtask
`endif

    task automatic release_reset();
        @(posedge forever_cpuclk);
        #2 cpurst_b = 1'b1;
`ifdef AQ_SPSRAM_INIT_EN
        check_sweep(128);
`endif
    endtask

    initial begin
        cpurst_b    = 1'b0;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, 7'd9, 8'h55, 8'hFF);
        #12;
        chk("rst_req_rdy", bus.req_rdy, 0);
        chk("rst_cen_gwen", {sram_cen, sram_gwen}, 2'b11);
        chk("rst_wen", sram_wen, 8'hFF);
        chk("rst_a_d", {sram_a, sram_d}, 0);
        chk("rst_rsp", {bus.rsp_vld, bus.rsp_rdata}, 0);
`ifdef AQ_SPSRAM_INIT_EN
        chk("rst_init_done", init_done, 0);
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        @(posedge forever_cpuclk);
        #2 cpurst_b = 1'b1;
        check_sweep(41);
        cpurst_b = 1'b0;
        #1 chk("midsweep_rst", {sram_cen, sram_a}, 8'h80);
        release_reset();
        rd_check(7'd5, 8'h00);
`else
        chk("rst_init_done", init_done, 1);
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        release_reset();
`endif

        wr_op(7'd3, 8'hA5, 8'hFF);
        chk("wr1_strobes", {sram_cen, sram_gwen, sram_wen}, 10'h000);
        chk("wr1_a_d", {sram_a, sram_d}, {7'd3, 8'hA5});
        wr_op(7'd3, 8'h0F, 8'h0F);
        chk("wr2_wen", sram_wen, 8'hF0);
        rd_check(7'd3, 8'hAF);

        for (int i = 0; i < 8; i++) wr_op(7'(i), 8'(8'h10 + i), 8'hFF);
        for (int t = 0; t < 10; t++) begin
            if (t < 8) begin
                drive(1'b1, 1'b0, 7'(t), 8'd0, 8'd0);
                #1 chk("b2b_rdy", bus.req_rdy, 1);
            end else begin
                drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
            end
            step();
            if (t >= 2) begin
                chk("b2b_vld", bus.rsp_vld, 1);
                chk("b2b_data", bus.rsp_rdata, 8'h10 + t - 2);
            end
        end
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        step();
        chk("b2b_drained", bus.rsp_vld, 0);

        bus.rsp_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 7'(k), 8'd0, 8'd0);
            #1 chk("crd_rdy", bus.req_rdy, (k < 4) ? 1 : 0);
            step();
        end
        wr_op(7'd20, 8'h5A, 8'hFF);
        chk("crd_wr_issued", {sram_cen, sram_gwen, sram_a}, {2'b00, 7'd20});
        drive(1'b1, 1'b0, 7'd6, 8'd0, 8'd0);
        #1 chk("crd_rd_stall", bus.req_rdy, 0);
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        step();
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("crd_drain_vld", bus.rsp_vld, 1);
            chk("crd_drain_data", bus.rsp_rdata, 8'h10 + i);
            step();
        end
        chk("crd_empty", bus.rsp_vld, 0);
        rd_check(7'd20, 8'h5A);

        drive(1'b1, 1'b1, 7'd9, 8'h33, 8'hFF);
        #1 step();
        rd_op(7'd9);
        step();
        step();
        chk("raw_vld", bus.rsp_vld, 1);
        chk("raw_data", bus.rsp_rdata, 8'h33);
        step();
        drive(1'b1, 1'b0, 7'd9, 8'd0, 8'd0);
        #1 step();
        drive(1'b1, 1'b1, 7'd9, 8'h44, 8'hFF);
        #1 chk("war_wr_rdy", bus.req_rdy, 1);
        step();
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);
        step();
        chk("war_vld", bus.rsp_vld, 1);
        chk("war_data", bus.rsp_rdata, 8'h33);
        step();
        rd_check(7'd9, 8'h44);

        bus.rsp_rdy = 1'b0;
        rd_op(7'd0);
        rd_op(7'd1);
        step();
        chk("pend_vld", bus.rsp_vld, 1);
        cpurst_b = 1'b0;
        #1;
        chk("midop_rst_rsp", {bus.rsp_vld, bus.rsp_rdata}, 0);
        chk("midop_rst_cen", sram_cen, 1);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midop_dropped", bus.rsp_vld, 0);
        end
        drive(1'b1, 1'b0, 7'd0, 8'd0, 8'd0);
        #1 chk("midop_credit_clear", bus.req_rdy, 1);
        drive(1'b0, 1'b0, 7'd0, 8'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
